// File: rtl/bin2bcd_refresh_pkg.sv
// bin2bcd_refresh_pkg: shared FSM encoding, saturation limit and default refresh interval
package bin2bcd_refresh_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;
  localparam logic [13:0] BCD_MAX = 14'd9999;
  localparam logic [25:0] REFRESH_MAX_DEF = 26'd50_000_000;
endpackage

// File: rtl/bin2bcd_refresh_add3.sv
// bcd_add3_nibble: double-dabble correction, din >= 5 -> din + 3
module bcd_add3_nibble (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_refresh.sv
// bin2bcd_refresh: rate-limited serial binary->4-digit BCD (bin_data/valid/ready in, data_bcd/bcd_valid/ovf out)
module bin2bcd_refresh
  import bin2bcd_refresh_pkg::*;
#(
  parameter int          BIN_W       = 14,
  parameter logic [25:0] REFRESH_MAX = REFRESH_MAX_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [BIN_W-1:0] bin_data,
  input  logic             bin_valid,
  output logic             bin_ready,
  output logic [15:0]      data_bcd,
  output logic             bcd_valid,
  output logic             ovf
);
  localparam int IW = $clog2(BIN_W + 1);
  localparam logic [25:0] RM1 = (REFRESH_MAX > 26'd1) ? REFRESH_MAX - 26'd1 : 26'd0;
  localparam logic [BIN_W-1:0] SAT = BIN_W'(BCD_MAX);
  localparam logic [IW-1:0] LAST = IW'(BIN_W - 1);
  state_t state, next;
  logic [IW-1:0] iter;
  logic [15+BIN_W:0] sreg;
  logic [15:0] adj;
  logic ovf_pending, refresh_ok, accept;
  logic [25:0] refresh_cnt;
  assign bin_ready = (state == IDLE) && refresh_ok;
  assign accept = bin_valid && bin_ready;
  for (genvar i = 0; i < 4; i++) begin : g_add3
    bcd_add3_nibble u_add3 (.din(sreg[BIN_W+4*i +: 4]), .dout(adj[4*i +: 4]));
  end
  always_comb
    next = (state == IDLE)  ? (accept ? SHIFT : IDLE) :
           (state == SHIFT) ? ((iter == LAST) ? COMMIT : SHIFT) : IDLE;
  always_ff @(posedge sys_clk)
    if (sys_rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      iter        <= '0;
      sreg        <= '0;
      ovf_pending <= 1'b0;
      refresh_cnt <= '0;
      refresh_ok  <= 1'b1;
      data_bcd    <= '0;
      ovf         <= 1'b0;
      bcd_valid   <= 1'b0;
    end else begin
      bcd_valid   <= state == COMMIT;
      // counter saturates at RM1 so refresh_ok cannot be re-armed by a wrap
      refresh_cnt <= (state == COMMIT) ? 26'd0 : (refresh_cnt != RM1) ? refresh_cnt + 26'd1 : refresh_cnt;
      refresh_ok  <= accept ? 1'b0 : (state == COMMIT) ? (REFRESH_MAX <= 26'd1) :
                     (refresh_cnt == RM1) ? 1'b1 : refresh_ok;
      if (accept) begin
        sreg        <= {16'h0, (bin_data > SAT) ? SAT : bin_data};
        ovf_pending <= bin_data > SAT;
        iter        <= '0;
      end
      if (state == SHIFT) begin
        sreg <= {adj, sreg[BIN_W-1:0]} << 1;
        iter <= iter + 1'b1;
      end
      if (state == COMMIT) begin
        data_bcd <= sreg[15+BIN_W:BIN_W];
        ovf      <= ovf_pending;
      end
    end
  end
endmodule
